// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU controller: ALU operation codes, RV32I opcodes,
// controller FSM state type and the branch-outcome helper.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_INC  = 4'b1010;
  localparam logic [3:0] ALU_DEC  = 4'b1011;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // funct3[2] picks SLT/SLTU (bit 0 of result) over SUB (zero test); funct3[0] inverts.
  function automatic logic br_decide(input logic [2:0] f3, input logic [31:0] res);
    return f3[2] ? (res[0] ^ f3[0]) : ((res == 32'd0) ^ f3[0]);
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32I decode for OP / OP-IMM (and BRANCH when ALU_CTRL_BRANCH_EN
// is defined) into an ALU operation plus operand-selection controls.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] op,
  output logic       use_imm,
  output logic       is_shift,
  output logic       is_branch,
  output logic       illegal
);

  logic [3:0] base_op;

  always_comb begin
    base_op = ALU_AND;
    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default up front so no decode path can infer a latch.
    op        = ALU_ADD;
    use_imm   = 1'b0;
    is_shift  = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b1;
    case (opcode)
      OPC_OP: begin
        op       = (funct3 == 3'b000 && funct7b5) ? ALU_SUB : base_op;
        is_shift = (funct3[1:0] == 2'b01);
        illegal  = funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101);
      end
      OPC_OP_IMM: begin
        // instr[30] is an immediate bit except for the shift-immediates.
        op       = base_op;
        use_imm  = 1'b1;
        is_shift = (funct3[1:0] == 2'b01);
        illegal  = funct7b5 && (funct3 == 3'b001);
      end
`ifdef ALU_CTRL_BRANCH_EN
      OPC_BRANCH: begin
        op        = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        is_branch = 1'b1;
        illegal   = (funct3[2:1] == 2'b01);
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// ALU controller: accepts one instruction, drives an external ALU for one cycle and
// holds the captured result until consumed. Define ALU_CTRL_BRANCH_EN for branches.
module alu_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_zf,
  input  logic        alu_cf,
  input  logic        alu_of,
  input  logic        alu_sf,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_flags,
  output logic        br_taken,
  output logic        illegal
);

  state_t      state;
  logic [3:0]  dec_op;
  logic        use_imm;
  logic        is_shift;
  logic        is_branch;
  logic        dec_illegal;
  logic [31:0] b_src;
  logic [31:0] b_next;

  alu_ctrl_dec u_dec (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .op        (dec_op),
    .use_imm   (use_imm),
    .is_shift  (is_shift),
    .is_branch (is_branch),
    .illegal   (dec_illegal)
  );

  assign b_src    = use_imm ? imm : rs2_val;
  assign b_next   = is_shift ? {27'd0, b_src[4:0]} : b_src;
  assign in_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register update here order-independent.
    if (!rst_n) begin
      state     <= S_IDLE;
      res_valid <= 1'b0;
      illegal   <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (dec_illegal) begin
              // ALU operands keep their previous values on an illegal encoding.
              state     <= S_DONE;
              res_valid <= 1'b1;
              illegal   <= 1'b1;
              res_data  <= '0;
              res_flags <= '0;
            end else begin
              state   <= S_EXEC;
              illegal <= 1'b0;
              alu_a   <= rs1_val;
              alu_b   <= b_next;
              alu_op  <= dec_op;
            end
          end
        end
        S_EXEC: begin
          state     <= S_DONE;
          res_valid <= 1'b1;
          res_data  <= alu_out;
          res_flags <= {alu_zf, alu_cf, alu_of, alu_sf};
        end
        S_DONE: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_CTRL_BRANCH_EN
  logic       br_pend;
  logic [2:0] br_f3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_taken <= 1'b0;
      br_pend  <= 1'b0;
      br_f3    <= '0;
    end else if (state == S_IDLE && in_valid) begin
      br_taken <= 1'b0;
      br_pend  <= is_branch && !dec_illegal;
      br_f3    <= funct3;
    end else if (state == S_EXEC) begin
      br_taken <= br_pend && br_decide(br_f3, alu_out);
    end
  end
`else
  logic unused_branch;
  assign unused_branch = is_branch;
  assign br_taken      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: acts as the external ALU, runs a directed vector
// table, reset corner cases and randomized instructions against an ISA-level model.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] rs1_val, rs2_val, imm;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        alu_zf, alu_cf, alu_of, alu_sf;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_flags;
  logic        br_taken;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] last_a, last_b;
  logic [3:0]  last_op;

  typedef struct packed {
    logic        legal;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        taken;
  } ref_t;

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        b5;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] im;
    ref_t        e;
    logic [3:0]  hold;
  } vec_t;

  alu_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .imm       (imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_zf    (alu_zf),
    .alu_cf    (alu_cf),
    .alu_of    (alu_of),
    .alu_sf    (alu_sf),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_flags (res_flags),
    .br_taken  (br_taken),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // External ALU behaviour.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a << b[4:0];
      4'b0010: return {31'd0, $signed(a) < $signed(b)};
      4'b0011: return {31'd0, a < b};
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1000: return a - b;
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      4'b1010: return a + 32'd1;
      4'b1011: return a - 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] alu_flg(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    logic [31:0] o;
    logic        cf, of;
    o  = alu_fn(a, b, op);
    cf = 1'b0;
    of = 1'b0;
    if (op == 4'b0000) begin
      cf = ({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF;
      of = (a[31] == b[31]) && (o[31] != a[31]);
    end else if (op == 4'b1000) begin
      cf = a < b;
      of = (a[31] != b[31]) && (o[31] != a[31]);
    end
    return {o == 32'd0, cf, of, o[31]};
  endfunction

  assign alu_out = alu_fn(alu_a, alu_b, alu_op);
  assign {alu_zf, alu_cf, alu_of, alu_sf} = alu_flg(alu_a, alu_b, alu_op);

  // ISA-level expectation: what the instruction means and which ALU op carries it.
  function automatic ref_t ref_model(input logic [6:0] opc, input logic [2:0] f3,
                                     input logic b5, input logic [31:0] r1,
                                     input logic [31:0] r2, input logic [31:0] im);
    ref_t        r;
    logic [31:0] x;
    logic        is_op;
    r     = '0;
    r.a   = r1;
    is_op = (opc == 7'b0110011);
    x     = is_op ? r2 : im;
    if (is_op || opc == 7'b0010011) begin
      r.b = x;
      case (f3)
        3'd0: if (is_op && b5) begin r.op = 4'b1000; r.res = r1 - x; end
              else begin r.op = 4'b0000; r.res = r1 + x; end
        3'd1: begin r.op = 4'b0001; r.res = r1 << x[4:0]; r.b = {27'd0, x[4:0]}; end
        3'd2: begin r.op = 4'b0010; r.res = ($signed(r1) < $signed(x)) ? 32'd1 : 32'd0; end
        3'd3: begin r.op = 4'b0011; r.res = (r1 < x) ? 32'd1 : 32'd0; end
        3'd4: begin r.op = 4'b0100; r.res = r1 ^ x; end
        3'd5: begin
          r.b = {27'd0, x[4:0]};
          if (b5) begin r.op = 4'b1101; r.res = $unsigned($signed(r1) >>> x[4:0]); end
          else begin r.op = 4'b0101; r.res = r1 >> x[4:0]; end
        end
        3'd6: begin r.op = 4'b0110; r.res = r1 | x; end
        default: begin r.op = 4'b0111; r.res = r1 & x; end
      endcase
      r.legal = is_op ? (!b5 || f3 == 3'd0 || f3 == 3'd5) : !(b5 && f3 == 3'd1);
    end
`ifdef ALU_CTRL_BRANCH_EN
    else if (opc == 7'b1100011) begin
      r.b     = r2;
      r.legal = 1'b1;
      case (f3)
        3'd0: begin r.op = 4'b1000; r.res = r1 - r2; r.taken = (r1 == r2); end
        3'd1: begin r.op = 4'b1000; r.res = r1 - r2; r.taken = (r1 != r2); end
        3'd4: begin r.op = 4'b0010; r.taken = $signed(r1) < $signed(r2); r.res = {31'd0, r.taken}; end
        3'd5: begin r.op = 4'b0010; r.taken = $signed(r1) >= $signed(r2); r.res = {31'd0, !r.taken}; end
        3'd6: begin r.op = 4'b0011; r.taken = r1 < r2; r.res = {31'd0, r.taken}; end
        3'd7: begin r.op = 4'b0011; r.taken = r1 >= r2; r.res = {31'd0, !r.taken}; end
        default: r.legal = 1'b0;
      endcase
    end
`endif
    if (!r.legal) begin
      r.res   = 32'd0;
      r.taken = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    last_a  = '0;
    last_b  = '0;
    last_op = '0;
  endtask

  // Drive one instruction, measure accept-to-result latency, check, then consume.
  task automatic run_txn(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic b5, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input ref_t e, input int hold);
    int          lat;
    logic [31:0] d0;
    @(negedge clk);
    opcode   = opc;
    funct3   = f3;
    funct7b5 = b5;
    rs1_val  = r1;
    rs2_val  = r2;
    imm      = im;
    in_valid = 1'b1;
    check({tag, " in_ready_idle"}, in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, e.legal ? 2 : 1);
    if (!res_valid) begin
      do_reset();
      return;
    end
    check({tag, " in_ready_done"}, in_ready, 1'b0);
    check({tag, " illegal"}, illegal, !e.legal);
    check({tag, " res_data"}, res_data, e.res);
    check({tag, " alu_op"}, alu_op, e.op);
    check({tag, " alu_a"}, alu_a, e.a);
    check({tag, " alu_b"}, alu_b, e.b);
    check({tag, " br_taken"}, br_taken, e.taken);
    if (e.legal) check({tag, " res_flags"}, res_flags, alu_flg(e.a, e.b, e.op));
    d0 = e.res;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold_valid"}, res_valid, 1'b1);
      check({tag, " hold_data"}, res_data, d0);
      check({tag, " hold_in_ready"}, in_ready, 1'b0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, " consumed_valid"}, res_valid, 1'b0);
    check({tag, " consumed_in_ready"}, in_ready, 1'b1);
    last_a  = e.a;
    last_b  = e.b;
    last_op = e.op;
  endtask

  function automatic vec_t mkv(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] im, input logic legal, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic taken, input int hold);
    vec_t v;
    v.opc     = opc;
    v.f3      = f3;
    v.b5      = b5;
    v.r1      = r1;
    v.r2      = r2;
    v.im      = im;
    v.e.legal = legal;
    v.e.op    = op;
    v.e.a     = a;
    v.e.b     = b;
    v.e.res   = res;
    v.e.taken = taken;
    v.hold    = hold[3:0];
    return v;
  endfunction

  vec_t vecs[9];

  initial begin
    ref_t        e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        b5;
    logic [31:0] r1, r2, im;
    logic [11:0] im12;

    vecs[0] = mkv(7'h33, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0,
                  1, 4'h0, 32'd5, 32'd7, 32'd12, 0, 5);
    vecs[1] = mkv(7'h13, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'h404,
                  1, 4'hD, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0);
    vecs[2] = mkv(7'h13, 3'd0, 1'b1, 32'd10, 32'd99, 32'hFFFF_FFFF,
                  1, 4'h0, 32'd10, 32'hFFFF_FFFF, 32'd9, 0, 1);
    vecs[3] = mkv(7'h7F, 3'd0, 1'b0, 32'd1, 32'd2, 32'd3,
                  0, 4'h0, 32'd10, 32'hFFFF_FFFF, 32'd0, 0, 2);
`ifdef ALU_CTRL_BRANCH_EN
    vecs[4] = mkv(7'h63, 3'd6, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0,
                  1, 4'h3, 32'd1, 32'hFFFF_FFFF, 32'd1, 1, 0);
    vecs[5] = mkv(7'h63, 3'd0, 1'b0, 32'd9, 32'd9, 32'd0,
                  1, 4'h8, 32'd9, 32'd9, 32'd0, 1, 0);
`else
    vecs[4] = mkv(7'h63, 3'd6, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0,
                  0, 4'h0, 32'd10, 32'hFFFF_FFFF, 32'd0, 0, 0);
    vecs[5] = mkv(7'h63, 3'd0, 1'b0, 32'd9, 32'd9, 32'd0,
                  0, 4'h0, 32'd10, 32'hFFFF_FFFF, 32'd0, 0, 0);
`endif
    vecs[6] = mkv(7'h33, 3'd0, 1'b1, 32'd3, 32'd5, 32'd0,
                  1, 4'h8, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 0);
    vecs[7] = mkv(7'h33, 3'd1, 1'b1, 32'd4, 32'd1, 32'd0,
                  0, 4'h8, 32'd3, 32'd5, 32'd0, 0, 0);
    vecs[8] = mkv(7'h33, 3'd5, 1'b0, 32'hF0, 32'h23, 32'd0,
                  1, 4'h5, 32'hF0, 32'd3, 32'h1E, 0, 0);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    opcode    = '0;
    funct3    = '0;
    funct7b5  = 1'b0;
    rs1_val   = '0;
    rs2_val   = '0;
    imm       = '0;
    do_reset();

    check("rst in_ready", in_ready, 1'b1);
    check("rst res_valid", res_valid, 1'b0);
    check("rst illegal", illegal, 1'b0);
    check("rst br_taken", br_taken, 1'b0);
    check("rst res_data", res_data, 32'd0);
    check("rst res_flags", res_flags, 4'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    check("rst alu_op", alu_op, 4'd0);

    for (int i = 0; i < 9; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].opc, vecs[i].f3, vecs[i].b5, vecs[i].r1,
              vecs[i].r2, vecs[i].im, vecs[i].e, int'(vecs[i].hold));

    // Reset while EXEC: result discarded, controller back in IDLE.
    @(negedge clk);
    opcode = 7'h33; funct3 = 3'd0; funct7b5 = 1'b0;
    rs1_val = 32'd100; rs2_val = 32'd23; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check("rst_exec res_valid", res_valid, 1'b0);
    check("rst_exec in_ready", in_ready, 1'b1);
    check("rst_exec res_data", res_data, 32'd0);
    check("rst_exec alu_op", alu_op, 4'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_exec no_pulse", res_valid, 1'b0);
    end

    // Reset while DONE after an illegal encoding.
    @(negedge clk);
    opcode = 7'h7F; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_done pre_valid", res_valid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_done res_valid", res_valid, 1'b0);
    check("rst_done illegal", illegal, 1'b0);
    check("rst_done in_ready", in_ready, 1'b1);
    last_a = '0; last_b = '0; last_op = '0;

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0:       opc = 7'b0110011;
        1:       opc = 7'b0010011;
        2:       opc = 7'b1100011;
        default: opc = 7'($urandom);
      endcase
      f3   = 3'($urandom);
      b5   = 1'($urandom);
      r1   = $urandom;
      r2   = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      im12 = 12'($urandom);
      im   = {{20{im12[11]}}, im12};
      e    = ref_model(opc, f3, b5, r1, r2, im);
      if (!e.legal) begin
        e.a  = last_a;
        e.b  = last_b;
        e.op = last_op;
      end
      run_txn($sformatf("rnd%0d", i), opc, f3, b5, r1, r2, im, e, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
